// File: rtl/aes_sbox_if.sv
// Request/response bundle between the round controller (port A), the key
// scheduler (port B) and the shared S-box server.
interface aes_sbox_if;
  logic         a_req_valid;
  logic [127:0] a_req_data;
  logic         a_req_ready;
  logic         a_rsp_valid;
  logic [127:0] a_rsp_data;
  logic         b_req_valid;
  logic [31:0]  b_req_data;
  logic         b_req_ready;
  logic         b_rsp_valid;
  logic [31:0]  b_rsp_data;

  modport master (
    output a_req_valid, a_req_data, b_req_valid, b_req_data,
    input  a_req_ready, a_rsp_valid, a_rsp_data,
    input  b_req_ready, b_rsp_valid, b_rsp_data
  );

  modport slave (
    input  a_req_valid, a_req_data, b_req_valid, b_req_data,
    output a_req_ready, a_rsp_valid, a_rsp_data,
    output b_req_ready, b_rsp_valid, b_rsp_data
  );
endinterface

// File: rtl/aes_sbox_arbiter.sv
// Shares NUM_SBOX forward S-box lanes between SubBytes (port A, 16 bytes) and
// SubWord (port B, 4 bytes); round-robin per job, NUM_SBOX bytes per cycle.
module aes_sbox_arbiter #(
  parameter int NUM_SBOX = 4
) (
  input  logic      clk,
  input  logic      rst,
  aes_sbox_if.slave bus,
  output logic      busy
);

  localparam int N_A   = 16 / NUM_SBOX;
  localparam int N_B   = (NUM_SBOX >= 4) ? 1 : 4 / NUM_SBOX;
  localparam int CNT_W = (N_A > 1) ? $clog2(N_A) : 1;

  generate
    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
        NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
      $error("aes_sbox_arbiter: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box, index 0 is the most significant byte.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  state_t             state, state_nxt;
  port_t              owner, last;
  logic [CNT_W-1:0]   cnt, cnt_last;
  logic [15:0][7:0]   work, result, result_nxt;
  logic               grant_a, grant_b, hs_a, hs_b;
  logic               a_ready, b_ready, a_rsp, b_rsp;
  logic [4:0]         base;
  logic [4:0]         lane_idx [NUM_SBOX];
  logic [7:0]         lane_out [NUM_SBOX];
  logic               lane_we  [NUM_SBOX];

  // The port not served last wins a tie; last resets to B so A wins first.
  assign grant_a  = bus.a_req_valid & (~bus.b_req_valid | (last == PORT_B));
  assign grant_b  = bus.b_req_valid & (~bus.a_req_valid | (last == PORT_A));
  assign hs_a     = bus.a_req_valid & a_ready;
  assign hs_b     = bus.b_req_valid & b_ready;
  assign cnt_last = (owner == PORT_A) ? CNT_W'(N_A - 1) : CNT_W'(N_B - 1);
  assign base     = 5'(cnt) * 5'(NUM_SBOX);

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    assign lane_idx[j] = base + 5'(j);
    assign lane_we[j]  = (owner == PORT_A) || (lane_idx[j] < 5'd4);
    assign lane_out[j] = sbox(work[lane_idx[j][3:0]]);
  end

  always_comb begin
    result_nxt = result;
    for (int j = 0; j < NUM_SBOX; j++) begin
      if (lane_we[j]) result_nxt[lane_idx[j][3:0]] = lane_out[j];
    end
  end

  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    a_rsp     = 1'b0;
    b_rsp     = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        a_ready = grant_a;
        b_ready = grant_b;
        if (grant_a || grant_b) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == cnt_last) state_nxt = DONE;
      end
      DONE: begin
        a_rsp     = (owner == PORT_A);
        b_rsp     = (owner == PORT_B);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last   <= PORT_B;
      owner  <= PORT_A;
      work   <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (hs_a) begin
            work  <= bus.a_req_data;
            owner <= PORT_A;
            last  <= PORT_A;
            cnt   <= '0;
          end else if (hs_b) begin
            work  <= {96'd0, bus.b_req_data};
            owner <= PORT_B;
            last  <= PORT_B;
            cnt   <= '0;
          end
        end
        RUN: begin
          result <= result_nxt;
          // Hold at N-1 on the final chunk so cnt never wraps.
          if (cnt != cnt_last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a_req_ready = a_ready;
  assign bus.b_req_ready = b_ready;
  assign bus.a_rsp_valid = a_rsp;
  assign bus.b_rsp_valid = b_rsp;
  assign bus.a_rsp_data  = result;
  assign bus.b_rsp_data  = result[3:0];

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter at NUM_SBOX = 1, 2 and 4, checked against a
// transaction-level model and an S-box derived from GF(2^8) inversion.
module tb_aes_sbox_arbiter;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         av [NI], bv [NI], ar [NI], br [NI], arv [NI], brv [NI], bsy [NI];
  logic [127:0] ad [NI], ard [NI];
  logic [31:0]  bd [NI], brd [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NSG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    aes_sbox_if bus ();
    assign bus.a_req_valid = av[g];
    assign bus.a_req_data  = ad[g];
    assign bus.b_req_valid = bv[g];
    assign bus.b_req_data  = bd[g];
    assign ar[g]  = bus.a_req_ready;
    assign br[g]  = bus.b_req_ready;
    assign arv[g] = bus.a_rsp_valid;
    assign brv[g] = bus.b_rsp_valid;
    assign ard[g] = bus.a_rsp_data;
    assign brd[g] = bus.b_rsp_data;
    aes_sbox_arbiter #(.NUM_SBOX(NSG)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (bsy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box from the multiplicative inverse plus the affine map.
  logic [7:0] tbl [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = tbl[d[8*i +: 8]];
    return r;
  endfunction

  function automatic int ns_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic int job_len(input int k, input bit isb);
    int n;
    n = ns_of(k);
    if (isb) return (n >= 4) ? 1 : 4 / n;
    return 16 / n;
  endfunction

  // Model: a job accepted in cycle t answers in t+N+1; the block is idle again from t+N+2.
  int           idle_from [NI];
  bit           last_b [NI], pend [NI], pend_b [NI];
  int           pend_cyc [NI];
  logic [127:0] pend_exp [NI];
  bit           m_idle, m_ga, m_gb, m_ea, m_eb, m_va, m_vb;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        m_idle = (cyc >= idle_from[k]);
        m_ga   = av[k] && (!bv[k] || last_b[k]);
        m_gb   = bv[k] && (!av[k] || !last_b[k]);
        m_ea   = m_idle && m_ga;
        m_eb   = m_idle && m_gb;
        m_va   = pend[k] && !pend_b[k] && (cyc == pend_cyc[k]);
        m_vb   = pend[k] &&  pend_b[k] && (cyc == pend_cyc[k]);
        check($sformatf("u%0d a_req_ready", k), ar[k], m_ea);
        check($sformatf("u%0d b_req_ready", k), br[k], m_eb);
        check($sformatf("u%0d busy", k), bsy[k], !m_idle);
        check($sformatf("u%0d a_rsp_valid", k), arv[k], m_va);
        check($sformatf("u%0d b_rsp_valid", k), brv[k], m_vb);
        if (m_va) check($sformatf("u%0d a_rsp_data", k), ard[k], pend_exp[k]);
        if (m_vb) check($sformatf("u%0d b_rsp_data", k), brd[k], pend_exp[k][31:0]);
        if (m_va || m_vb) pend[k] = 1'b0;
        if (rst) begin
          idle_from[k] = cyc + 1;
          pend[k]      = 1'b0;
          last_b[k]    = 1'b1;
        end else if (m_ea || m_eb) begin
          pend[k]      = 1'b1;
          pend_b[k]    = m_eb;
          pend_cyc[k]  = cyc + job_len(k, m_eb) + 1;
          idle_from[k] = cyc + job_len(k, m_eb) + 2;
          pend_exp[k]  = m_eb ? sub128({96'd0, bd[k]}) : sub128(ad[k]);
          last_b[k]    = m_eb;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k, input bit isb, input logic [127:0] d,
                         output int waited, output int lat, output logic [127:0] rdata);
    int hs, got;
    hs = -1; got = -1; waited = 0; rdata = '0; lat = -1;
    if (isb) begin bv[k] = 1'b1; bd[k] = d[31:0]; end
    else     begin av[k] = 1'b1; ad[k] = d;       end
    for (int i = 0; i < 200 && hs < 0; i++) begin
      @(negedge clk);
      if ((isb ? br[k] : ar[k]) && !rst) hs = cyc;
      else waited++;
      tick();
    end
    if (isb) bv[k] = 1'b0; else av[k] = 1'b0;
    if (hs < 0) begin
      check("handshake_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < 200 && got < 0; i++) begin
      @(negedge clk);
      if (isb ? brv[k] : arv[k]) begin
        got   = cyc;
        rdata = isb ? {96'd0, brd[k]} : ard[k];
      end
    end
    tick();
    if (got < 0) check("response_timeout", 0, 1);
    else lat = got - hs;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d tests", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           waited, lat, n, a_hs, a_rsp, b_hs, b_got, spurious;
    logic [127:0] rdata, d;
    logic [31:0]  rb;
    logic [3:0]   seq;
    bit           hsa [NI], hsb [NI];

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, xb;
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (xb != 0 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      tbl[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int k = 0; k < NI; k++) begin
      av[k] = 1'b0; bv[k] = 1'b0; ad[k] = '0; bd[k] = '0;
      idle_from[k] = 0; last_b[k] = 1'b1; pend[k] = 1'b0; pend_b[k] = 1'b0;
      pend_cyc[k] = 0; pend_exp[k] = '0;
    end
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("u%0d reset a_rsp_data", k), ard[k], '0);
      check($sformatf("u%0d reset b_rsp_data", k), brd[k], '0);
    end
    tick();

    // Port B, zero word, NUM_SBOX=4.
    run_job(2, 1'b1, '0, waited, lat, rdata);
    check("b_zero ready_at_once", waited, 0);
    check("b_zero latency", lat, 2);
    check("b_zero data", rdata[31:0], 32'h63636363);

    // Port A, byte k = k, NUM_SBOX=1 and 4.
    d = 128'h0f0e0d0c0b0a09080706050403020100;
    run_job(0, 1'b0, d, waited, lat, rdata);
    check("a_ramp ns1 latency", lat, 17);
    check("a_ramp ns1 low bytes", rdata[31:0], 32'h7b777c63);
    check("a_ramp ns1 byte15", rdata[127:120], 8'h76);
    run_job(2, 1'b0, d, waited, lat, rdata);
    check("a_ramp ns4 latency", lat, 5);
    check("a_ramp ns4 low bytes", rdata[31:0], 32'h7b777c63);
    check("a_ramp ns4 byte15", rdata[127:120], 8'h76);

    // Tie right after reset, then four jobs with both ports held valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    av[2] = 1'b1; ad[2] = {16{8'h53}};
    bv[2] = 1'b1; bd[2] = 32'hffffffff;
    n = 0; seq = '0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (arv[2]) check("tie a_data", ard[2], {16{8'hed}});
      if (brv[2]) check("tie b_data", brd[2], 32'h16161616);
      if (ar[2] && av[2]) begin seq[n] = 1'b0; n++; end
      else if (br[2] && bv[2]) begin seq[n] = 1'b1; n++; end
      tick();
    end
    av[2] = 1'b0; bv[2] = 1'b0;
    check("tie grant count", n, 4);
    check("tie grant sequence", seq, 4'b1010);
    b_got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (brv[2]) begin b_got++; check("tie last b_data", brd[2], 32'h16161616); end
    end
    check("tie last b_rsp seen", b_got, 1);
    tick();

    // B raised during an A job waits for the first IDLE after DONE.
    d  = {$urandom, $urandom, $urandom, $urandom};
    rb = $urandom;
    av[2] = 1'b1; ad[2] = d;
    @(negedge clk);
    check("late_b a_ready", ar[2], 1'b1);
    a_hs = cyc;
    tick();
    av[2] = 1'b0;
    bv[2] = 1'b1; bd[2] = rb;
    b_hs = -1; a_rsp = -1;
    for (int i = 0; i < 100 && b_hs < 0; i++) begin
      @(negedge clk);
      if (arv[2]) begin a_rsp = cyc; check("late_b a_data", ard[2], sub128(d)); end
      if (br[2]) b_hs = cyc;
      tick();
    end
    bv[2] = 1'b0;
    check("late_b a_latency", a_rsp - a_hs, 5);
    check("late_b b_handshake_cycle", b_hs - a_rsp, 1);
    b_got = -1;
    for (int i = 0; i < 10 && b_got < 0; i++) begin
      @(negedge clk);
      if (brv[2]) begin b_got = cyc; check("late_b b_data", brd[2], sub128({96'd0, rb}) & 128'hffffffff); end
    end
    check("late_b b_latency", b_got - b_hs, 2);
    tick();

    // Reset during the second RUN cycle of an A job.
    d = {$urandom, $urandom, $urandom, $urandom};
    av[2] = 1'b1; ad[2] = d;
    @(negedge clk);
    check("abort a_ready", ar[2], 1'b1);
    tick();
    av[2] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort busy_after_reset", bsy[2], 1'b0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (arv[2]) spurious++;
    end
    check("abort no a_rsp", spurious, 0);
    tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    run_job(2, 1'b0, d, waited, lat, rdata);
    check("abort fresh a_data", rdata, sub128(d));
    check("abort fresh latency", lat, 5);

    // Every byte value through port A at NUM_SBOX=2.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(4 * i + j);
      run_job(1, 1'b0, d, waited, lat, rdata);
      check($sformatf("sweep job%0d data", i), rdata, sub128(d));
      check($sformatf("sweep job%0d latency", i), lat, 9);
    end

    // Random traffic on all instances with occasional resets.
    for (int k = 0; k < NI; k++) begin hsa[k] = 1'b0; hsb[k] = 1'b0; end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        hsa[k] = av[k] && ar[k] && !rst;
        hsb[k] = bv[k] && br[k] && !rst;
      end
      tick();
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < NI; k++) begin
        if (!av[k] || hsa[k]) begin
          av[k] = ($urandom_range(0, 2) != 0);
          ad[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (!bv[k] || hsb[k]) begin
          bv[k] = ($urandom_range(0, 2) != 0);
          bd[k] = $urandom;
        end
      end
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin av[k] = 1'b0; bv[k] = 1'b0; end
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_sbox_arbiter.md
# aes_sbox_arbiter

Time-multiplexed S-box server that shares `NUM_SBOX` instances of the combinational forward S-box between two requesters. Port A is the round datapath's SubBytes (16 bytes). Port B is the key-expansion SubWord (4 bytes). The block arbitrates round-robin at job granularity, feeds each job through the S-box lanes `NUM_SBOX` bytes per cycle, and returns the substituted word with a one-cycle response pulse. It sits between the round controller / key scheduler and the S-box instances, replacing 20 dedicated S-boxes.

## Interface
- `NUM_SBOX`, default 4: S-box lanes instantiated. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_req_valid` in 1: port A request present.
- `a_req_data` in 128: state bytes; byte k = bits [8k+7:8k].
- `a_req_ready` out 1: port A request accepted this cycle.
- `a_rsp_valid` out 1: port A result valid, one-cycle pulse.
- `a_rsp_data` out 128: SubBytes(a_req_data), same byte order.
- `b_req_valid` in 1: port B request present.
- `b_req_data` in 32: word bytes; byte k = bits [8k+7:8k].
- `b_req_ready` out 1: port B request accepted this cycle.
- `b_rsp_valid` out 1: port B result valid, one-cycle pulse.
- `b_rsp_data` out 32: SubWord(b_req_data).
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- Grant (combinational, IDLE only):
  - If only one port is valid, that port is granted.
  - If both are valid, the port not served last is granted.
  - The `last` pointer resets to B, so A wins the first tie.
- `x_req_ready` = IDLE & grant==x. A handshake is `x_req_valid & x_req_ready`.
- On handshake:
  - Latch data into the 128-bit `work` register (port B zero-extended).
  - Set `owner` and `last` to x, `cnt` to 0, and go to RUN.
- Job length in chunks:
  - N_A = 16/NUM_SBOX.
  - N_B = max(1, 4/NUM_SBOX).
- RUN, each cycle:
  - Lane j receives `work` byte cnt*NUM_SBOX+j.
  - Its output is written to the same byte index of `result`.
  - For port B, only byte indices < 4 are written; lanes at higher indices are don't-care.
  - `cnt` increments.
  - On the cycle with `cnt` == N_owner−1, go to DONE.
- DONE:
  - Assert `owner`'s `rsp_valid` for exactly one cycle.
  - `a_rsp_data` = `result`; `b_rsp_data` = `result[31:0]`.
  - Next state is IDLE.
- `rsp_data` outputs are driven from `result` continuously. They are meaningful only while the matching `rsp_valid` is high and may change at any other time.
- Requesters must hold `req_valid` and `req_data` stable until the handshake completes. The block samples data only at the handshake.
- There is no response backpressure. Requesters must accept the pulse.
- `cnt` width is clog2(16/NUM_SBOX), minimum 1 bit. It never wraps past N−1.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0, `last` = B, `owner` = A.
  - `result` = 0, `work` = 0.
  - All `rsp_valid` = 0; `busy` = 0.
  - `a_req_ready` / `b_req_ready` follow the grant logic in IDLE and are not forced low.
- Handshake at cycle t:
  - RUN occupies cycles t+1 … t+N.
  - DONE, with the response pulse, is cycle t+N+1.
  - IDLE resumes at t+N+2, and the next handshake can occur in that cycle.
- Latency, handshake to `rsp_valid`, is N+1 cycles. Examples at NUM_SBOX=4: A = 5, B = 2. At NUM_SBOX=1: A = 17, B = 5.
- Throughput is one job per N+2 cycles. There is no overlap of jobs.
- A request arriving during RUN or DONE waits; `req_ready` stays 0 until IDLE.
- With both ports continuously valid, service alternates A, B, A, B…
- Reset asserted mid-job:
  - The job is abandoned and no `rsp_valid` is produced.
  - The FSM is in IDLE in the cycle after `rst` deasserts.
  - The requester must re-present its request.
- If `rst` is high in the same cycle as a handshake, reset wins and nothing is latched.

## Test plan
- Reset, then `b_req_data` = 0x00000000 at NUM_SBOX=4:
  - `b_req_ready` is 1 in the handshake cycle.
  - `b_rsp_valid` pulses 2 cycles later with data 0x63636363.
  - `a_rsp_valid` stays 0.
- Port A with byte k = k (0x0F0E…0100), at NUM_SBOX=1 and again at NUM_SBOX=4:
  - Low bytes of the result are 0x63, 0x7C, 0x77, 0x7B.
  - Byte 15 is 0x76.
  - Latency is 17 cycles (NUM_SBOX=1) and 5 cycles (NUM_SBOX=4).
- A and B valid in the same IDLE cycle right after reset: A is granted first (all bytes 0x53 → all 0xED); B is granted at the next IDLE (0xFFFFFFFF → 0x16161616). Hold both valid for four jobs and check the grant sequence is A, B, A, B.
- Request B asserted during an A RUN:
  - `b_req_ready` stays 0 through RUN and DONE.
  - The handshake occurs in the first IDLE cycle after DONE.
  - The A response is unaffected.
- `rst` pulsed for 1 cycle during the 2nd RUN cycle of an A job:
  - No `a_rsp_valid` appears.
  - `busy` is 0 in the next cycle.
  - A fresh A request then completes with correct data.
- Exhaustive: 64 port-A jobs cover all 256 byte values at NUM_SBOX=2; every response matches the FIPS-197 table.
